// File: rtl/flasher_pkg.sv
// Shared types and limits for the flick scheduler that fronts one bound_flasher.
package flasher_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_START,
    S_RUN,
    S_COOLDOWN
  } sched_state_t;

  localparam int LED_W = 16;

  localparam int PULSE_W = 4;
  localparam int TIMER_W = 8;

  localparam int N_REQ_MIN     = 2;
  localparam int N_REQ_MAX     = 8;
  localparam int FLICK_LEN_MIN = 1;
  localparam int FLICK_LEN_MAX = 15;
  localparam int START_TO_MIN  = 1;
  localparam int START_TO_MAX  = 255;
  localparam int COOL_MAX      = 255;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: search starts just after the last granted index.
module rr_arbiter
  import flasher_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last,
  output logic [N_REQ-1:0] winner
);

  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    // Offsets 1..N_REQ visit every requester once, with `last` itself tried last.
    for (int i = 1; i <= N_REQ; i++) begin
      idx = IW'((int'(last) + i) % N_REQ);
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/flick_scheduler.sv
// Shares one bound_flasher among N_REQ requesters: grant, flick pulse, watch LED, cool down.
// req is a level request; grant is held from grant to release regardless of req afterwards.
module flick_scheduler
  import flasher_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int FLICK_LEN = 1,
  parameter int START_TO  = 8,
  parameter int COOL      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [LED_W-1:0] led,
  output logic             flick,
  output logic [N_REQ-1:0] grant,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int IW = $clog2(N_REQ);

  localparam logic [PULSE_W-1:0] PULSE_LEN  = PULSE_W'(FLICK_LEN);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(START_TO - 1);
  localparam logic [TIMER_W-1:0] COOL_LAST  = TIMER_W'((COOL == 0) ? 0 : COOL - 1);
  localparam logic [IW-1:0]      LAST_RST   = IW'(N_REQ - 1);

  if (N_REQ < N_REQ_MIN || N_REQ > N_REQ_MAX ||
      FLICK_LEN < FLICK_LEN_MIN || FLICK_LEN > FLICK_LEN_MAX ||
      START_TO < START_TO_MIN || START_TO > START_TO_MAX ||
      COOL < 0 || COOL > COOL_MAX) begin : g_param_check
    $error("flick_scheduler: parameter out of range");
  end

  sched_state_t       state;
  logic [PULSE_W-1:0] pulse_cnt;
  logic [TIMER_W-1:0] timer;
  logic [TIMER_W-1:0] cool_cnt;
  logic [IW-1:0]      last;
  logic [IW-1:0]      grant_idx;
  logic [N_REQ-1:0]   winner;
  logic [IW-1:0]      win_idx;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_arb (
    .req    (req),
    .last   (last),
    .winner (winner)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (winner[i]) win_idx = IW'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pulse_cnt <= '0;
      timer     <= '0;
      cool_cnt  <= '0;
      last      <= LAST_RST;
      grant_idx <= '0;
      flick     <= 1'b0;
      grant     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|req) begin
            grant     <= winner;
            grant_idx <= win_idx;
            flick     <= 1'b1;
            busy      <= 1'b1;
            pulse_cnt <= PULSE_LEN;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (pulse_cnt <= PULSE_W'(1)) begin
            flick <= 1'b0;
            timer <= '0;
            state <= S_WAIT_START;
          end else begin
            pulse_cnt <= pulse_cnt - PULSE_W'(1);
          end
        end
        S_WAIT_START: begin
          if (led != '0) begin
            state <= S_RUN;
          end else if (timer >= TIMER_LAST) begin
            // Flasher never lit: give up without a cooldown.
            err   <= 1'b1;
            grant <= '0;
            busy  <= 1'b0;
            last  <= grant_idx;
            state <= S_IDLE;
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end
        S_RUN: begin
          // LED back to zero ends the run, including a flasher reset mid-sequence.
          if (led == '0) begin
            done     <= 1'b1;
            last     <= grant_idx;
            cool_cnt <= '0;
            state    <= S_COOLDOWN;
          end
        end
        S_COOLDOWN: begin
          if (cool_cnt >= COOL_LAST) begin
            grant <= '0;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            cool_cnt <= cool_cnt + TIMER_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/flick_scheduler.md
# flick_scheduler

Round-robin scheduler that shares one `bound_flasher` instance among N independent requesters. It grants one requester at a time and drives the flasher's `flick` input with a registered pulse of programmable width. It then tracks the running light sequence through the flasher's `LED` bus and releases the flasher only after the sequence returns to all-off plus a cooldown. It sits between the request sources (buttons, software strobes) and the `bound_flasher` `flick` pin.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `FLICK_LEN`, default 1: flick pulse width in clk cycles, 1..15.
- `START_TO`, default 8: maximum number of cycles to wait for `LED != 0` after the pulse ends, 1..255.
- `COOL`, default 4: idle cycles after the sequence ends before the next grant, 0..255.

- `clk`, in, 1: the single clock. All state changes on the posedge.
- `rst_n`, in, 1: synchronous, active-low reset, sampled on the posedge of `clk`.
- `req`, in, N_REQ: level requests. Bit i is requester i.
- `led`, in, 16: `LED` bus of the shared `bound_flasher`.
- `flick`, out, 1: registered flick to the flasher.
- `grant`, out, N_REQ: one-hot grant, held from grant to release.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse when the granted sequence completes.
- `err`, out, 1: one-cycle pulse on start timeout.

## Operation
- States: IDLE, ISSUE, WAIT_START, RUN, COOLDOWN.
- **IDLE**
  - Requests are evaluated by round-robin priority, starting at `(last+1) mod N_REQ`.
  - If any `req` bit is set: latch the winner into `grant`, set `flick=1`, load the pulse counter with FLICK_LEN, and go to ISSUE.
- **ISSUE**
  - `flick` stays high for exactly FLICK_LEN cycles.
  - Then `flick=0`, the timer is cleared, and the block goes to WAIT_START.
- **WAIT_START**
  - `led != 0` → RUN.
  - Otherwise the timer increments each cycle. When it reaches START_TO: pulse `err`, clear `grant`, update `last`, and go to IDLE with no cooldown.
- **RUN**
  - Stays in RUN while `led != 0`. No further flick is issued, so kickback restarts are never triggered by this block.
  - First cycle with `led == 0`: pulse `done`, update `last` to the granted index, and go to COOLDOWN.
  - `grant` stays held during COOLDOWN.
- **COOLDOWN**
  - Counts COOL cycles, then clears `grant` and goes to IDLE.
  - With COOL=0, the transition to IDLE happens on the next cycle.
- **Requests after the grant:** deassertion of the granted `req` never aborts the sequence. Requests arriving while busy are not queued; they are honoured only if still held when IDLE is re-entered.
- **Flasher reset mid-sequence:** the flasher drives `LED=0`, which RUN treats as normal completion (`done` pulses).
- **Counter widths:** pulse counter 4 bits, timer and cooldown counter 8 bits. No counter wraps; each saturates at its terminal compare.

## Timing
- **Reset:** while `rst_n=0` at a posedge, the next state is IDLE and all outputs are 0 (`flick`, `grant`, `busy`, `done`, `err`). `last` resets to N_REQ-1, so requester 0 has first priority.
- **Reset beats everything:** `rst_n=0` in the same cycle as a `req` produces no grant. Reset mid-ISSUE drops `flick` on the next edge.
- **Grant latency:** `req` sampled high in IDLE at edge k → `grant`, `flick` and `busy` are all high after edge k.
- **Pulse width:** `flick` is high for exactly FLICK_LEN cycles.
- **`done` and `err`:** each is exactly 1 cycle and they are mutually exclusive. `done` rises on the edge after `led==0` is first sampled in RUN.
- **Back-to-back grants:** the minimum gap from `grant` falling to the next `grant` rising is 1 cycle (the IDLE evaluation).

## Structure
- Package `flasher_pkg`:
  - state enum `sched_state_t`;
  - constant `LED_W=16`;
  - parameter range limits.
- Sub-module `rr_arbiter`: combinational round-robin with inputs `req` and `last` and a one-hot winner output. It is instantiated once.

## Test plan
- **Single request:** N_REQ=4, FLICK_LEN=1, `req=4'b0100` held for 1 cycle in IDLE.
  - `grant=0100` and `flick` high for 1 cycle.
  - Flasher model runs its sequence. `done` pulses 1 cycle after `LED` returns to 0.
  - `grant` clears after COOL=4 cycles.
- **Fairness:** `req=4'b1111` held continuously → grants in the order 0001, 0010, 0100, 1000, 0001. No requester is granted twice in a row.
- **Start timeout:** flasher stubbed with `LED=0` forever, START_TO=8.
  - `err` pulses exactly 8 cycles after `flick` falls.
  - `done` never pulses, and IDLE is re-entered with no cooldown.
- **Flasher reset mid-sequence:** flasher `rst_n` asserted for 100 ns during RUN → `done` pulses and COOLDOWN follows. A second `req` is granted afterwards.
- **Scheduler reset:** `rst_n=0` for 2 cycles during ISSUE with FLICK_LEN=3.
  - `flick=0`, `grant=0` and `busy=0` after the edge.
  - `req=0001` held through reset → granted on the first cycle after `rst_n=1`.
- **Pulse width:** FLICK_LEN=3 and `req` dropped during ISSUE → `flick` is still exactly 3 cycles wide and the sequence completes.
